// File: rtl/axi_hs_pkg.sv
// Shared definitions for the AXI4 write-data handshake blocks (master sender
// and slave completion detector).
package axi_hs_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } wd_state_e;

    // AXI4 INCR bursts carry at most 256 beats (AWLEN = 8'hFF).
    localparam int AXI4_MAX_BURST = 256;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/wd_beat_reg.sv
// One-entry holding register on the W channel. A new beat may be loaded in the
// same cycle the current one is handshaken, which sustains one beat per cycle.
module wd_beat_reg #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [STRB_WIDTH-1:0] load_strb,
    input  logic                  load_last,
    input  logic                  WREADY,
    output logic                  WVALID,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WLAST
);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            WVALID <= 1'b0;
            WLAST  <= 1'b0;
            WDATA  <= '0;
            WSTRB  <= '0;
        end else if (load) begin
            WVALID <= 1'b1;
            WLAST  <= load_last;
            WDATA  <= load_data;
            WSTRB  <= load_strb;
        end else if (WVALID && WREADY) begin
            // Data/strobes are left as-is; only the qualifiers drop.
            WVALID <= 1'b0;
            WLAST  <= 1'b0;
        end
    end

endmodule

// File: rtl/wd_burst_sender.sv
// AXI4 master W-channel transmitter: takes one burst length, pulls len+1 beats
// from a streaming source and presents them on W with WLAST on the final beat.
module wd_burst_sender
    import axi_hs_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int LEN_WIDTH  = 8,
    localparam int STRB_WIDTH = strb_width(DATA_WIDTH)
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  Cmd_Valid,
    output logic                  Cmd_Ready,
    input  logic [LEN_WIDTH-1:0]  Cmd_Len,
    input  logic                  Src_Valid,
    output logic                  Src_Ready,
    input  logic [DATA_WIDTH-1:0] Src_Data,
    input  logic [STRB_WIDTH-1:0] Src_Strb,
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic [STRB_WIDTH-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  Burst_Done
);

    // One extra bit so a 256-beat burst counts to len+1 without wrapping.
    localparam int CNT_WIDTH = LEN_WIDTH + 1;

    wd_state_e            state;
    logic [LEN_WIDTH-1:0] len_q;
    logic [CNT_WIDTH-1:0] fetch_cnt;
    logic [CNT_WIDTH-1:0] send_cnt;
    logic [CNT_WIDTH-1:0] len_ext;
    logic                 load;
    logic                 load_last;
    logic                 w_hs;
    logic                 last_hs;

    assign len_ext   = CNT_WIDTH'(len_q);
    assign Cmd_Ready = (state == IDLE);
    assign Src_Ready = (state == SEND) && (fetch_cnt <= len_ext) && (!WVALID || WREADY);
    assign load      = Src_Valid && Src_Ready;
    assign load_last = (fetch_cnt == len_ext);
    assign w_hs      = WVALID && WREADY;
    assign last_hs   = w_hs && WLAST;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state      <= IDLE;
            len_q      <= '0;
            fetch_cnt  <= '0;
            send_cnt   <= '0;
            Burst_Done <= 1'b0;
        end else begin
            Burst_Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Cmd_Valid) begin
                        state     <= SEND;
                        len_q     <= Cmd_Len;
                        fetch_cnt <= '0;
                        send_cnt  <= '0;
                    end
                end
                SEND: begin
                    if (load)
                        fetch_cnt <= fetch_cnt + CNT_WIDTH'(1);
                    if (w_hs)
                        send_cnt <= send_cnt + CNT_WIDTH'(1);
                    // No load can coincide with the last handshake: fetch_cnt
                    // is already past len_q, so the beat register empties here.
                    if (last_hs) begin
                        state      <= IDLE;
                        Burst_Done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wd_beat_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH)
    ) u_beat_reg (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .load      (load),
        .load_data (Src_Data),
        .load_strb (Src_Strb),
        .load_last (load_last),
        .WREADY    (WREADY),
        .WVALID    (WVALID),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WLAST     (WLAST)
    );

    a_last_matches_count: assert property (@(posedge ACLK) disable iff (!ARESETN)
        w_hs |-> ((send_cnt == len_ext) == WLAST));

endmodule

// File: tb/tb_wd_burst_sender.sv
// Scoreboard bench for wd_burst_sender: stimulus pushes expected beats,
// a negedge monitor pops and compares on every W handshake.
module tb_wd_burst_sender;
    localparam int DW = 32;
    localparam int LW = 8;
    localparam int SW = DW / 8;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          Cmd_Valid = 1'b0;
    logic          Cmd_Ready;
    logic [LW-1:0] Cmd_Len = '0;
    logic          Src_Valid = 1'b0;
    logic          Src_Ready;
    logic [DW-1:0] Src_Data = '0;
    logic [SW-1:0] Src_Strb = '0;
    logic          WVALID;
    logic          WREADY = 1'b1;
    logic [DW-1:0] WDATA;
    logic [SW-1:0] WSTRB;
    logic          WLAST;
    logic          Burst_Done;

    wd_burst_sender #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready), .Cmd_Len(Cmd_Len),
        .Src_Valid(Src_Valid), .Src_Ready(Src_Ready), .Src_Data(Src_Data), .Src_Strb(Src_Strb),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .Burst_Done(Burst_Done)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    beat_t src_q[$];
    beat_t exp_q[$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, done_cnt = 0, hs_cnt = 0, src_cnt = 0, cur_len = 0, last_hs_cyc = -10;
    int smode = 0, wmode = 0, stall_left = 0;
    bit stall_done = 1'b0, tog = 1'b0, mon_en = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [SW-1:0] ps = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not seen within bound (cycle %0d)", name, cyc);
    endtask

    // Source and WREADY drivers, updated 1 time unit after each rising edge.
    always @(posedge ACLK) begin
        bit g;
        cyc++;
        #1;
        tog = ~tog;
        case (smode)
            0:       g = 1'b1;
            1:       g = tog;
            default: g = ($urandom_range(0, 1) == 1);
        endcase
        Src_Valid = (src_q.size() > 0) && g;
        if (src_q.size() > 0) begin
            Src_Data = src_q[0].data;
            Src_Strb = src_q[0].strb;
        end
        case (wmode)
            0: WREADY = 1'b1;
            1: WREADY = ($urandom_range(0, 3) != 0);
            default: begin
                if (stall_left > 0) begin
                    WREADY = 1'b0;
                    stall_left--;
                end else if (!stall_done && WVALID && hs_cnt == 1) begin
                    WREADY = 1'b0;
                    stall_left = 2;
                    stall_done = 1'b1;
                end else begin
                    WREADY = 1'b1;
                end
            end
        endcase
    end

    // Monitor: protocol checks plus scoreboard pop on every W handshake.
    always @(negedge ACLK) begin
        beat_t e;
        if (mon_en) begin
            if (pv && !pr) begin
                chk("hold_wvalid", WVALID, 1);
                chk("hold_wdata", WDATA, pd);
                chk("hold_wstrb", WSTRB, ps);
                chk("hold_wlast", WLAST, pl);
            end
            if (WVALID && !WREADY) chk("stall_src_ready", Src_Ready, 0);
            if (Src_Ready) chk("src_limit", (src_cnt <= cur_len), 1);
        end
        if (Src_Valid && Src_Ready) begin
            src_cnt++;
            if (src_q.size() > 0) src_q.delete(0);
        end
        if (mon_en && WVALID && WREADY) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL extra_beat: got wdata %0h expected no beat", WDATA);
            end else begin
                e = exp_q.pop_front();
                chk("wdata", WDATA, e.data);
                chk("wstrb", WSTRB, e.strb);
                chk("wlast", WLAST, e.last);
            end
            if (WLAST) last_hs_cyc = cyc;
        end
        if (mon_en && Burst_Done) begin
            chk("done_timing", cyc, last_hs_cyc + 1);
            chk("done_cmd_ready", Cmd_Ready, 1);
            done_cnt++;
        end
        pv = WVALID; pr = WREADY; pl = WLAST; pd = WDATA; ps = WSTRB;
    end

    task automatic load_burst(input int len, input logic [DW-1:0] base, input bit fixed);
        beat_t b;
        src_q.delete();
        for (int i = 0; i <= len; i++) begin
            b.data = fixed ? base + DW'(i) : DW'($urandom);
            b.strb = fixed ? {SW{1'b1}} : SW'($urandom);
            b.last = (i == len);
            src_q.push_back(b);
            exp_q.push_back(b);
        end
        // One surplus source beat that must never be taken.
        b.data = 32'hDEAD_BEEF; b.strb = '0; b.last = 1'b0;
        src_q.push_back(b);
        cur_len = len; src_cnt = 0; hs_cnt = 0; stall_done = 1'b0; stall_left = 0;
    endtask

    task automatic issue_cmd(input int len);
        int t = 0;
        @(posedge ACLK); #1;
        Cmd_Valid = 1'b1;
        Cmd_Len = len[LW-1:0];
        do begin @(negedge ACLK); t++; end while (!Cmd_Ready && t < 20);
        if (!Cmd_Ready) fail("cmd_accept");
        @(posedge ACLK); #1;
        Cmd_Valid = 1'b0;
    endtask

    task automatic run_burst(input int len, input logic [DW-1:0] base, input bit fixed,
                             input int sm, input int wm, input bit lat);
        int d0, t, k;
        smode = sm; wmode = wm;
        load_burst(len, base, fixed);
        d0 = done_cnt;
        issue_cmd(len);
        if (lat) begin
            k = 0;
            do begin @(negedge ACLK); k++; end while (!WVALID && k < 10);
            chk("first_wvalid_latency", k, 2);
        end
        t = 0;
        while (done_cnt == d0 && t < (len + 1) * 8 + 40) begin @(negedge ACLK); t++; end
        if (done_cnt == d0) fail("burst_done");
        repeat (2) @(negedge ACLK);
        chk("beats_sent", hs_cnt, len + 1);
        chk("src_consumed", src_cnt, len + 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_once", done_cnt - d0, 1);
    endtask

    initial begin
        int t, d0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_wlast", WLAST, 0);
        chk("rst_wdata", WDATA, 0);
        chk("rst_wstrb", WSTRB, 0);
        chk("rst_done", Burst_Done, 0);
        chk("rst_cmd_ready", Cmd_Ready, 1);
        chk("rst_src_ready", Src_Ready, 0);
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        mon_en = 1'b1;

        run_burst(3, 32'hA0, 1'b1, 0, 0, 1'b1);
        run_burst(0, 32'h55AA55AA, 1'b1, 0, 0, 1'b0);
        run_burst(2, '0, 1'b0, 0, 2, 1'b0);
        run_burst(4, '0, 1'b0, 1, 0, 1'b0);
        run_burst(255, '0, 1'b0, 0, 0, 1'b0);

        // Reset partway through a Cmd_Len=7 burst.
        smode = 0; wmode = 0;
        load_burst(7, '0, 1'b0);
        issue_cmd(7);
        t = 0;
        while (hs_cnt < 2 && t < 100) begin @(negedge ACLK); t++; end
        if (hs_cnt < 2) fail("midburst_beats");
        @(posedge ACLK); #1;
        ARESETN = 1'b0;
        mon_en = 1'b0;
        d0 = done_cnt;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("midrst_wvalid", WVALID, 0);
        chk("midrst_cmd_ready", Cmd_Ready, 1);
        chk("midrst_done", Burst_Done, 0);
        chk("midrst_wdata", WDATA, 0);
        src_q.delete();
        exp_q.delete();
        @(posedge ACLK); #1;
        mon_en = 1'b1;
        repeat (4) @(negedge ACLK);
        chk("midrst_no_done", done_cnt, d0);
        run_burst(1, '0, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 8; i++)
            run_burst($urandom_range(0, 20), '0, 1'b0, $urandom_range(0, 2), $urandom_range(0, 1), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/wd_burst_sender.md
Name: wd_burst_sender

Overview:
- Master-side AXI4 write-data (W) channel transmitter: accepts one burst command (beat count), pulls beats from a streaming data source, and drives WDATA/WSTRB/WVALID/WLAST to the interconnect.
- Raises WLAST on the final beat and pulses Burst_Done when that beat's handshake completes.
- Pairs with the slave-side write-data completion detector; both ends see identical WVALID/WREADY/WLAST semantics.

Parameters:
- DATA_WIDTH, 32, WDATA/Src_Data width in bits (multiple of 8).
- LEN_WIDTH, 8, width of Cmd_Len (AXI4 AWLEN encoding, beats minus 1).
- STRB_WIDTH, DATA_WIDTH/8, derived localparam, not overridable.

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- Cmd_Valid  in  1  burst command valid.
- Cmd_Ready  out  1  sender idle, command accepted this cycle if Cmd_Valid.
- Cmd_Len  in  LEN_WIDTH  beats minus 1 for the burst.
- Src_Valid  in  1  source beat available.
- Src_Ready  out  1  sender takes source beat this cycle.
- Src_Data  in  DATA_WIDTH  source beat data.
- Src_Strb  in  STRB_WIDTH  source beat byte strobes.
- WVALID  out  1  AXI W valid.
- WREADY  in  1  AXI W ready.
- WDATA  out  DATA_WIDTH  AXI W data.
- WSTRB  out  STRB_WIDTH  AXI W strobes.
- WLAST  out  1  AXI W last beat.
- Burst_Done  out  1  one-cycle pulse, final beat handshaken.

Behaviour:
- Reset (ARESETN low at a rising edge):
  - State becomes IDLE.
  - WVALID, WLAST, Burst_Done, WDATA and WSTRB are 0.
  - Counters are 0.
  - Reset mid-burst abandons the burst silently; no Burst_Done.
- States: IDLE, SEND.
  - Cmd_Ready = (state==IDLE), so it reads 1 out of reset.
  - Src_Ready is 0 in IDLE.
- IDLE -> SEND on Cmd_Valid && Cmd_Ready.
  - Latch Cmd_Len into len_q.
  - Clear fetch_cnt and send_cnt.
- SEND, one-entry output register:
  - Src_Ready = (fetch_cnt <= len_q) && (!WVALID || WREADY).
  - On Src_Valid && Src_Ready, at the next edge: load WDATA/WSTRB, set WVALID=1, set WLAST = (fetch_cnt == len_q), increment fetch_cnt.
  - On WVALID && WREADY without a new load: WVALID=0, WLAST=0. WDATA/WSTRB hold their value.
- AXI stability: while WVALID && !WREADY, WDATA, WSTRB and WLAST hold stable and WVALID stays 1.
- Throughput: one beat per cycle when Src_Valid and WREADY are held high.
  - Latency: command accepted at edge N; first WVALID at edge N+2.
- Completion: the edge with WVALID && WREADY && WLAST does all of the following:
  - sets Burst_Done=1 for exactly one cycle;
  - sets state to IDLE;
  - clears WVALID.
  - A new command can be accepted in that same following cycle.
- Counters are LEN_WIDTH+1 bits, so Cmd_Len = all-ones (256 beats) does not wrap.
  - send_cnt increments on every W handshake.
  - send_cnt == len_q must coincide with WLAST; this is an assertion for verification.
- Cmd_Len = 0 produces a single beat with WLAST=1 on that beat.
- No source beats are accepted beyond len_q+1.
  - Source stalls (Src_Valid=0) insert WVALID=0 bubbles only.
  - WVALID never drops mid-handshake.
- Simultaneous events in one cycle:
  - W handshake plus source load: the register reloads and WVALID stays 1.
  - Last-beat handshake plus Cmd_Valid: the command is not taken; Cmd_Ready is 0 in SEND.

Decomposition:
- Shared package axi_hs_pkg holds:
  - state enumeration (IDLE, SEND);
  - AXI4 max burst constant (256);
  - STRB width helper.
- One natural sub-module: wd_beat_reg, the one-entry valid/ready holding register for WDATA/WSTRB/WLAST/WVALID. The top keeps the FSM and counters.

Test Plan:
- Reset, then Cmd_Len=3 with Src_Valid and WREADY held 1, data 0xA0..0xA3 -> four consecutive WVALID beats. WLAST only on 0xA3. Burst_Done pulses 1 cycle after the 0xA3 handshake. First WVALID 2 cycles after command accept.
- Cmd_Len=0, data 0x55AA55AA, WSTRB 0xF -> single beat with WLAST=1; Burst_Done next cycle; Cmd_Ready=1 that cycle.
- Cmd_Len=2 with WREADY low for 3 cycles on beat 1 -> WDATA/WSTRB/WLAST stable and WVALID=1 throughout. Src_Ready=0 during the stall. Order is preserved.
- Cmd_Len=4 with Src_Valid toggling 1,0,1,0... -> WVALID bubbles only; exactly 5 beats; only 5 source beats consumed; WLAST on the 5th.
- Cmd_Len=255 at full rate -> 256 beats, WLAST on beat 256, no counter wrap, Burst_Done once.
- ARESETN low for 1 cycle after beat 2 of a Cmd_Len=7 burst -> WVALID=0, Cmd_Ready=1, no Burst_Done. A following Cmd_Len=1 burst completes normally.
